// File: rtl/mips_cpu_registers.sv
// MIPS32 general-purpose register file: 32 x 32-bit, two combinational read ports, one clocked write port.
// Optional build macro REGFILE_BYPASS_EN enables same-cycle write-through forwarding to both read ports.
module mips_cpu_registers #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic [ADDR_WIDTH-1:0] rdAddrA,
    output logic [DATA_WIDTH-1:0] rdDataA,
    input  logic [ADDR_WIDTH-1:0] rdAddrB,
    output logic [DATA_WIDTH-1:0] rdDataB
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_en;

    // $0 is never written, so it stays at its reset value of zero.
    assign wr_en = write && (wrAddr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wrAddr] <= wrData;
        end
    end

    always_comb begin
        rdDataA = (rdAddrA == '0) ? '0 : regs[rdAddrA];
        rdDataB = (rdAddrB == '0) ? '0 : regs[rdAddrB];
`ifdef REGFILE_BYPASS_EN
        // Forward the pending write so decode sees it before the edge; reset suppresses it.
        if (reset && wr_en && (rdAddrA == wrAddr)) begin
            rdDataA = wrData;
        end
        if (reset && wr_en && (rdAddrB == wrAddr)) begin
            rdDataB = wrData;
        end
`else
        if (!reset) begin
            rdDataA = '0;
            rdDataB = '0;
        end
`endif
    end

endmodule

// File: tb/tb_mips_cpu_registers.sv
// Self-checking bench for mips_cpu_registers: directed cases plus a randomized run against a shadow array.
// Build with +define+REGFILE_BYPASS_EN to exercise same-cycle forwarding.
module tb_mips_cpu_registers;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          write;
    logic [AW-1:0] wrAddr;
    logic [W-1:0]  wrData;
    logic [AW-1:0] rdAddrA;
    logic [W-1:0]  rdDataA;
    logic [AW-1:0] rdAddrB;
    logic [W-1:0]  rdDataB;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [W-1:0] model [32];
    logic [W-1:0] exp_q [$];

    mips_cpu_registers dut (
        .clk     (clk),
        .reset   (reset),
        .write   (write),
        .wrAddr  (wrAddr),
        .wrData  (wrData),
        .rdAddrA (rdAddrA),
        .rdDataA (rdDataA),
        .rdAddrB (rdAddrB),
        .rdDataB (rdDataB)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Shadow model: reset clears everything, $0 writes dropped, write lands at the rising edge.
    always @(negedge reset) begin
        for (int i = 0; i < 32; i++) model[i] = '0;
    end

    always @(posedge clk) begin
        if (reset === 1'b1 && write === 1'b1 && wrAddr != 0) model[wrAddr] = wrData;
    end

    function automatic logic [W-1:0] expected_read(input logic [AW-1:0] addr);
        if (reset !== 1'b1) return '0;
        if (addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (write === 1'b1 && wrAddr != 0 && addr == wrAddr) return wrData;
`endif
        return model[addr];
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard pop for hand-computed literal expectations
    task automatic check_q(input string name, input logic [W-1:0] act);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expected queue empty, got %08h", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    // Compare process: mid-cycle, inputs stable, both ports against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_portA", rdDataA, expected_read(rdAddrA));
            check("cmp_portB", rdDataB, expected_read(rdAddrB));
        end
    end

    // Driver tasks: inputs move 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        write   = we;
        wrAddr  = wa;
        wrData  = wd;
        rdAddrA = ra;
        rdAddrB = rb;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        drive(1'b0, '0, '0, '0, '0);
        reset = 1'b0;

        // 1: every address reads 0 on both ports while reset is low
        step();
        for (int a = 0; a < 32; a++) begin
            rdAddrA = a[AW-1:0];
            rdAddrB = 5'(31 - a);
            #0.1;
            check("reset_readA", rdDataA, '0);
            check("reset_readB", rdDataB, '0);
        end
        step();
        reset = 1'b1;
        cmp_en = 1'b1;

        // 2: write 5 then read it on both ports
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        step();
        write = 1'b0;
        #1;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        check_q("wr5_portA", rdDataA);
        check_q("wr5_portB", rdDataB);

        // Same-index read and write: old value before the edge (new value with forwarding), new value after
        drive(1'b1, 5'd5, 32'h11112222, 5'd5, 5'd6);
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'h11112222);
`else
        exp_q.push_back(32'hDEADBEEF);
`endif
        #1;
        check_q("rw_same_pre_edge", rdDataA);
        step();
        write = 1'b0;
        #1;
        exp_q.push_back(32'h11112222);
        check_q("rw_same_post_edge", rdDataA);

        // 3: writes to $0 are discarded
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        check("zero_pre_edge", rdDataA, '0);
        step();
        write = 1'b0;
        #1;
        check("zero_post_edge", rdDataA, '0);

        // 4: write=0 leaves reg 7 untouched
        drive(1'b0, 5'd7, 32'h12345678, 5'd7, 5'd7);
        step();
        #1;
        check("nowrite_reg7", rdDataA, '0);

        // 5: reset between edges clears at once and kills the pending write
        drive(1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd31);
        step();
        drive(1'b1, 5'd3, 32'h0BADF00D, 5'd31, 5'd3);
        #1;
        check("reg31_loaded", rdDataA, 32'hCAFEF00D);
        reset = 1'b0;
        #0.5;
        check("async_reset_reg31", rdDataA, '0);
        check("async_reset_portB", rdDataB, '0);
        step();
        reset = 1'b1;
        write = 1'b0;
        #1;
        check("pending_write_lost", rdDataB, '0);
        check("reg31_after_reset", rdDataA, '0);

`ifdef REGFILE_BYPASS_EN
        drive(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd1);
        #1;
        check("bypass_reg9", rdDataA, 32'hA5A5A5A5);
        step();
        write = 1'b0;
`endif

        // 6: randomized run with occasional resets
        for (int c = 0; c < 300; c++) begin
            logic [AW-1:0] wa;
            wa = AW'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, $urandom(),
                  ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31)));
            if (reset == 1'b0) reset = 1'b1;
            else if ($urandom_range(0, 99) == 0 || c == 150) reset = 1'b0;
            step();
        end
        reset = 1'b1;
        write = 1'b0;
        step();
        step();
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
